nonogram_option_gen: RTL and testbench

//  Writer end of the solver's option FIFO stream. Takes one line's clue list (a row or a column) and enumerates every legal placement of the clue blocks.

---
 rtl/nonogram_option_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_nonogram_option_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonogram_option_gen.sv
// nonogram_option_gen
// Enumerates every legal placement of one line's clue blocks and streams a
// header word (the line index) followed by one bitmask word per placement.
// When the line is finished, a one-cycle count pulse feeds the
// options-amount table. Block positions are held as start cells p[k].
// The enumeration steps the right-most movable block and re-packs every
// block to its right against it.

module nonogram_option_gen #(
    parameter int MAX_ROWS        = 11,
    parameter int MAX_COLS        = 11,
    parameter int MAX_CLUES       = 6,
    parameter int MAX_NUM_OPTIONS = 84,
    localparam int LD = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS,
    localparam int IW = $clog2(MAX_ROWS + MAX_COLS),
    localparam int CW = $clog2(MAX_NUM_OPTIONS),
    localparam int LW = $clog2(LD) + 1,
    localparam int KW = $clog2(MAX_CLUES) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      line_valid,
    output logic                      line_ready,
    input  logic [IW-1:0]             line_index,
    input  logic [LW-1:0]             line_len,
    input  logic [KW-1:0]             clue_count,
    input  logic [MAX_CLUES-1:0][3:0] clues,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               out_data,
    output logic                      out_header,
    output logic                      cnt_valid,
    output logic [IW-1:0]             cnt_line,
    output logic [CW-1:0]             cnt_value,
    output logic                      infeasible
);

    // Positions and running sums. Six 4-bit clues plus separators stay below 256.
    localparam int PW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_HEADER,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [IW-1:0]             line_index_reg;
    logic [LW-1:0]             line_len_reg;
    logic [KW-1:0]             clue_count_reg;
    logic [MAX_CLUES-1:0][3:0] clues_reg;
    logic [PW-1:0]             pos_reg [MAX_CLUES];
    logic [CW-1:0]             count_reg;
    logic                      infeasible_reg;

    logic [PW-1:0] init_pos [MAX_CLUES];
    logic [PW-1:0] adv_pos  [MAX_CLUES];
    logic [PW-1:0] packed_end;
    logic          check_fail;
    logic          adv_found;
    logic [15:0]   block_mask [MAX_CLUES];
    logic [15:0]   option_word;

    genvar gi;

    // Left-packed start positions. The final running value equals sum(clues)+K.
    always_comb begin : pack_left
        logic [PW-1:0] run;
        run = '0;
        for (int j = 0; j < MAX_CLUES; j++) begin
            init_pos[j] = run;
            if (KW'(j) < clue_count_reg)
                run = run + PW'(clues_reg[j]) + PW'(1);
        end
        packed_end = run;
    end

    // The line cannot hold the clues when sum+K-1 > len, which is the same as sum+K > len+1.
    assign check_fail = (clue_count_reg > KW'(MAX_CLUES)) ||
                        (line_len_reg == '0) ||
                        ((clue_count_reg != '0) &&
                         (packed_end > (PW'(line_len_reg) + PW'(1))));

    // Find the right-most block that can move one cell. Build the successor placement.
    always_comb begin : advance
        logic [PW-1:0] run;
        logic [PW-1:0] tmp;
        logic          can;
        int            sel;
        adv_found = 1'b0;
        sel       = 0;
        for (int k = 0; k < MAX_CLUES; k++) begin
            // tmp is the exclusive end of block k after a one-cell shift.
            tmp = pos_reg[k] + PW'(clues_reg[k]) + PW'(1);
            can = 1'b0;
            if (KW'(k) < clue_count_reg) begin
                if (KW'(k + 1) == clue_count_reg)
                    can = (tmp <= PW'(line_len_reg));
                else
                    can = (tmp < pos_reg[(k + 1) % MAX_CLUES]);
            end
            if (can) begin
                adv_found = 1'b1;
                sel       = k;
            end
        end
        run = '0;
        for (int j = 0; j < MAX_CLUES; j++) begin
            if (!adv_found || j < sel)
                tmp = pos_reg[j];
            else if (j == sel)
                tmp = pos_reg[j] + PW'(1);
            else
                tmp = run;
            adv_pos[j] = tmp;
            run = tmp + PW'(clues_reg[j]) + PW'(1);
        end
    end

    // One run of ones per active block, placed at the block's start cell.
    generate
        for (gi = 0; gi < MAX_CLUES; gi++) begin : g_block
            assign block_mask[gi] = (KW'(gi) < clue_count_reg)
                ? (((16'(1) << clues_reg[gi]) - 16'(1)) << pos_reg[gi])
                : 16'(0);
        end
    endgenerate

    // Merge the block runs. Clear cells past the line end and past the longest line.
    always_comb begin : merge_mask
        logic [15:0] acc;
        acc = '0;
        for (int k = 0; k < MAX_CLUES; k++)
            acc = acc | block_mask[k];
        acc = acc & ((16'(1) << line_len_reg) - 16'(1));
        acc = acc & ((16'(1) << LD) - 16'(1));
        option_word = acc;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state and output decode.
    always_comb begin
        state_next = state_reg;
        line_ready = 1'b0;
        out_valid  = 1'b0;
        out_header = 1'b0;
        out_data   = '0;
        cnt_valid  = 1'b0;
        cnt_line   = '0;
        cnt_value  = '0;
        infeasible = 1'b0;
        case (state_reg)
            S_IDLE: begin
                line_ready = 1'b1;
                if (line_valid)
                    state_next = S_CHECK;
            end
            S_CHECK: begin
                state_next = check_fail ? S_DONE : S_HEADER;
            end
            S_HEADER: begin
                out_valid  = 1'b1;
                out_header = 1'b1;
                out_data   = 16'(line_index_reg);
                if (out_ready)
                    state_next = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = option_word;
                if (out_ready && !adv_found)
                    state_next = S_DONE;
            end
            S_DONE: begin
                cnt_valid  = 1'b1;
                cnt_line   = line_index_reg;
                cnt_value  = count_reg;
                infeasible = infeasible_reg;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Descriptor capture, position stepping and the saturating option count.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_index_reg <= '0;
            line_len_reg   <= '0;
            clue_count_reg <= '0;
            clues_reg      <= '0;
            pos_reg        <= '{default: '0};
            count_reg      <= '0;
            infeasible_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (line_valid) begin
                        line_index_reg <= line_index;
                        line_len_reg   <= line_len;
                        clue_count_reg <= clue_count;
                        clues_reg      <= clues;
                        count_reg      <= '0;
                        infeasible_reg <= 1'b0;
                    end
                end
                S_CHECK: begin
                    pos_reg        <= init_pos;
                    infeasible_reg <= check_fail;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (count_reg < CW'(MAX_NUM_OPTIONS))
                            count_reg <= count_reg + CW'(1);
                        if (adv_found)
                            pos_reg <= adv_pos;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonogram_option_gen.sv
// Testbench for nonogram_option_gen: directed and random lines. A brute-force
// reference model enumerates every cell mask, keeps the masks whose runs match
// the clue list, and orders them by their block start tuples.

module tb_nonogram_option_gen;

    localparam int MAXC   = 6;
    localparam int MAXOPT = 84;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 line_valid;
    logic                 line_ready;
    logic [4:0]           line_index;
    logic [4:0]           line_len;
    logic [3:0]           clue_count;
    logic [MAXC-1:0][3:0] clues;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_data;
    logic                 out_header;
    logic                 cnt_valid;
    logic [4:0]           cnt_line;
    logic [6:0]           cnt_value;
    logic                 infeasible;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_words[$];
    int          exp_keys[$];
    bit          exp_inf;
    int          cl_v[MAXC];

    nonogram_option_gen dut (
        .clk       (clk),
        .rst       (rst),
        .line_valid(line_valid),
        .line_ready(line_ready),
        .line_index(line_index),
        .line_len  (line_len),
        .clue_count(clue_count),
        .clues     (clues),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_header(out_header),
        .cnt_valid (cnt_valid),
        .cnt_line  (cnt_line),
        .cnt_value (cnt_value),
        .infeasible(infeasible)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: every mask of len cells whose runs equal the clue list, sorted by start tuple.
    task automatic build_expected(input int len, input int k, input int cl[MAXC]);
        int sum, nr, i, st, key, pos;
        bit match;
        int starts[12];
        int lens[12];
        exp_words.delete();
        exp_keys.delete();
        exp_inf = 0;
        if (k > MAXC || len == 0) begin
            exp_inf = 1;
            return;
        end
        sum = 0;
        for (int j = 0; j < k; j++) sum += cl[j];
        if (k > 0 && sum + k - 1 > len) begin
            exp_inf = 1;
            return;
        end
        for (int m = 0; m < (1 << len); m++) begin
            nr = 0;
            i  = 0;
            while (i < len) begin
                if (((m >> i) & 1) == 1) begin
                    st = i;
                    while (i < len && ((m >> i) & 1) == 1) i++;
                    if (nr < 12) begin
                        starts[nr] = st;
                        lens[nr]   = i - st;
                    end
                    nr++;
                end else begin
                    i++;
                end
            end
            match = (nr == k);
            for (int r = 0; r < k && match; r++)
                if (lens[r] != cl[r]) match = 0;
            if (match) begin
                key = 0;
                for (int r = 0; r < k; r++) key = key * 16 + starts[r];
                pos = 0;
                while (pos < exp_keys.size() && exp_keys[pos] < key) pos++;
                exp_keys.insert(pos, key);
                exp_words.insert(pos, 16'(m));
            end
        end
    endtask

    // mode 0: out_ready always 1, mode 1: random, mode 2: repeating 1,0,0,1
    task automatic run_line(input int idx, input int len, input int k, input int cl[MAXC], input int mode);
        logic [15:0] got_words[$];
        int          cyc, guard, hdr_cycle, hdr_count, bubbles, stray, pcount, exp_cnt, nchk;
        logic [31:0] hdr_val, got_cnt, got_line;
        logic        got_inf, done, prev_stall, prev_hdr;
        logic [15:0] prev_data;
        build_expected(len, k, cl);
        guard = 0;
        while (!line_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_value("line_ready_idle", line_ready, 1);
        line_valid = 1'b1;
        line_index = idx[4:0];
        line_len   = len[4:0];
        clue_count = k[3:0];
        for (int j = 0; j < MAXC; j++) clues[j] = 4'(cl[j]);
        out_ready = 1'b0;
        @(negedge clk);
        line_valid = 1'b0;
        line_index = 5'($urandom);
        line_len   = 5'($urandom);
        clue_count = 4'($urandom);
        clues      = 24'($urandom);
        check_value("line_ready_busy", line_ready, 0);
        cyc = 1; hdr_cycle = -1; hdr_count = 0; bubbles = 0; stray = 0; pcount = 0;
        hdr_val = '0; got_cnt = '0; got_line = '0; got_inf = 1'b0; done = 1'b0;
        prev_stall = 1'b0; prev_hdr = 1'b0; prev_data = '0;
        while (!done && cyc < 400) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    out_ready = ((pcount % 4) == 0) || ((pcount % 4) == 3);
                    pcount++;
                end
            endcase
            if (prev_stall) begin
                check_value("stall_valid", out_valid, 1);
                check_value("stall_data", out_data, prev_data);
                check_value("stall_header", out_header, prev_hdr);
            end
            prev_stall = 1'b0;
            if (out_valid) begin
                if (out_header && hdr_cycle < 0) hdr_cycle = cyc;
                if (out_ready) begin
                    if (out_header) begin
                        hdr_count++;
                        hdr_val = 32'(out_data);
                    end else begin
                        got_words.push_back(out_data);
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                    prev_hdr   = out_header;
                end
            end else if (hdr_count > 0 && !cnt_valid) begin
                bubbles++;
            end
            if (cnt_valid) begin
                done     = 1'b1;
                got_cnt  = 32'(cnt_value);
                got_line = 32'(cnt_line);
                got_inf  = infeasible;
            end else if (infeasible) begin
                stray++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        exp_cnt = (exp_words.size() > MAXOPT) ? MAXOPT : exp_words.size();
        check_value("cnt_valid_seen", done, 1);
        check_value("infeasible", got_inf, exp_inf);
        check_value("cnt_value", got_cnt, exp_cnt);
        check_value("cnt_line", got_line, idx);
        check_value("header_count", hdr_count, exp_inf ? 0 : 1);
        if (!exp_inf) begin
            check_value("header_data", hdr_val, idx);
            check_value("header_latency", hdr_cycle, 2);
        end
        check_value("word_count", got_words.size(), exp_words.size());
        nchk = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
        for (int i = 0; i < nchk; i++)
            check_value($sformatf("word%0d", i), got_words[i], exp_words[i]);
        check_value("valid_bubbles", bubbles, 0);
        check_value("stray_infeasible", stray, 0);
        $display("line idx=%0d len=%0d K=%0d mode=%0d words=%0d exp_words=%0d cnt=%0d infeasible=%0d",
                 idx, len, k, mode, got_words.size(), exp_words.size(), got_cnt, got_inf);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int len, k;
        rst        = 1'b1;
        line_valid = 1'b0;
        line_index = '0;
        line_len   = '0;
        clue_count = '0;
        clues      = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_line_ready", line_ready, 1);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_out_header", out_header, 0);
        check_value("rst_out_data", out_data, 0);
        check_value("rst_cnt_valid", cnt_valid, 0);
        check_value("rst_cnt_line", cnt_line, 0);
        check_value("rst_cnt_value", cnt_value, 0);
        check_value("rst_infeasible", infeasible, 0);
        rst = 1'b0;
        @(negedge clk);

        cl_v = '{2, 0, 0, 0, 0, 0}; run_line(5, 5, 1, cl_v, 0);
        cl_v = '{1, 1, 0, 0, 0, 0}; run_line(1, 3, 2, cl_v, 0);
        cl_v = '{0, 0, 0, 0, 0, 0}; run_line(12, 11, 0, cl_v, 0);
        cl_v = '{1, 1, 1, 0, 0, 0}; run_line(21, 11, 3, cl_v, 0);
        cl_v = '{3, 3, 0, 0, 0, 0}; run_line(7, 5, 2, cl_v, 0);
        cl_v = '{2, 0, 0, 0, 0, 0}; run_line(4, 5, 1, cl_v, 2);
        cl_v = '{1, 1, 1, 1, 1, 1}; run_line(9, 11, 6, cl_v, 1);
        cl_v = '{1, 1, 1, 1, 1, 1}; run_line(10, 11, 7, cl_v, 0);
        cl_v = '{1, 0, 0, 0, 0, 0}; run_line(3, 0, 1, cl_v, 0);
        cl_v = '{1, 1, 1, 0, 0, 0}; run_line(2, 11, 3, cl_v, 1);

        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(1, 11);
            k   = $urandom_range(0, 6);
            for (int j = 0; j < MAXC; j++) cl_v[j] = (j < k) ? $urandom_range(1, 4) : 0;
            run_line($urandom_range(0, 21), len, k, cl_v, $urandom_range(0, 2));
        end

        // Reset in the middle of the option stream.
        while (!line_ready) @(negedge clk);
        line_valid = 1'b1;
        line_index = 5'd3;
        line_len   = 5'd11;
        clue_count = 4'd1;
        clues      = '0;
        clues[0]   = 4'd1;
        out_ready  = 1'b1;
        @(negedge clk);
        line_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_value("pre_rst_valid", out_valid, 1);
        check_value("pre_rst_header", out_header, 0);
        rst = 1'b1;
        @(negedge clk);
        check_value("mid_rst_out_valid", out_valid, 0);
        check_value("mid_rst_line_ready", line_ready, 1);
        check_value("mid_rst_cnt_valid", cnt_valid, 0);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (cnt_valid || out_valid) pulses++;
        end
        check_value("post_rst_quiet", pulses, 0);
        $display("line reset mid-emit: out_valid=%0d line_ready=%0d stray_activity=%0d", out_valid, line_ready, pulses);
        out_ready = 1'b0;
        cl_v = '{2, 1, 0, 0, 0, 0}; run_line(6, 7, 2, cl_v, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
